// File: rtl/fifo_mc_ptr_if.sv
// Bundle of write-side, read-side, flush and status signals for the
// shared-memory multi-channel FIFO pointer block.
interface fifo_mc_ptr_if #(
  parameter int N_log = 8,
  parameter int C_log = 2
);
  localparam int C = 2 ** C_log;

  logic [C_log-1:0]       i_wr_chan;
  logic                   i_wr_advance;
  logic [C_log+N_log-1:0] o_wr_adr;
  logic [C-1:0]           o_wr_full;
  logic [C-1:0]           o_wr_afull;
  logic [C_log-1:0]       i_rd_chan;
  logic                   i_rd_advance;
  logic [C_log+N_log-1:0] o_rd_adr;
  logic [C-1:0]           o_rd_empty;
  logic [C-1:0]           i_flush;
  logic [C*(N_log+1)-1:0] o_words;

  modport master (
    output i_wr_chan, i_wr_advance, i_rd_chan, i_rd_advance, i_flush,
    input  o_wr_adr, o_wr_full, o_wr_afull, o_rd_adr, o_rd_empty, o_words
  );

  modport slave (
    input  i_wr_chan, i_wr_advance, i_rd_chan, i_rd_advance, i_flush,
    output o_wr_adr, o_wr_full, o_wr_afull, o_rd_adr, o_rd_empty, o_words
  );
endinterface

// File: rtl/fifo_mc_ptr.sv
// Pointer, fill-state and word-count tracking for 2**C_log FIFOs that share
// one simple dual-port RAM, each channel owning a 2**N_log-word region.
module fifo_mc_ptr #(
  parameter int N_log        = 8,
  parameter int C_log        = 2,
  parameter int AF_THRESH    = 2 ** N_log - 4,
  parameter int RD_PTR_UNBUF = 1
) (
  input  logic         clk,
  input  logic         rst,
  fifo_mc_ptr_if.slave bus
);
  localparam int          C          = 2 ** C_log;
  localparam int          W          = N_log + 1;
  localparam logic [31:0] AF_U       = AF_THRESH;
  localparam logic        AF_AT_ZERO = (AF_THRESH == 0);

  logic [N_log-1:0] wr_ptr_q_all   [C];
  logic [N_log-1:0] rd_ptr_sel_all [C];

  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_chan
      logic [N_log-1:0] wr_ptr_reg, wr_ptr_next;
      logic [N_log-1:0] rd_ptr_reg, rd_ptr_next;
      logic             full_reg, full_next;
      logic             empty_reg, empty_next;
      logic             afull_reg, afull_next;
      logic [W-1:0]     words_reg, words_next;
      logic             wr_adv, rd_adv, ptr_eq;

      // Flush wins over any advance on this channel; full/empty gate the rest.
      assign wr_adv = bus.i_wr_advance & (bus.i_wr_chan == C_log'(gi)) &
                      ~full_reg & ~bus.i_flush[gi];
      assign rd_adv = bus.i_rd_advance & (bus.i_rd_chan == C_log'(gi)) &
                      ~empty_reg & ~bus.i_flush[gi];

      always_comb begin
        wr_ptr_next = wr_ptr_reg + N_log'(wr_adv);
        rd_ptr_next = rd_ptr_reg + N_log'(rd_adv);
        ptr_eq      = (wr_ptr_next == rd_ptr_next);
        full_next   = ptr_eq & (full_reg | wr_adv) & ~rd_adv;
        empty_next  = ptr_eq & (empty_reg | rd_adv) & ~wr_adv;
        // The full flag supplies the MSB so a full channel reads 2**N_log.
        words_next  = {full_next, wr_ptr_next - rd_ptr_next};
        afull_next  = (32'(words_next) >= AF_U);
      end

      always_ff @(posedge clk) begin
        if (rst || bus.i_flush[gi]) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          full_reg   <= 1'b0;
          empty_reg  <= 1'b1;
          afull_reg  <= AF_AT_ZERO;
          words_reg  <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
          full_reg   <= full_next;
          empty_reg  <= empty_next;
          afull_reg  <= afull_next;
          words_reg  <= words_next;
        end
      end

      assign wr_ptr_q_all[gi]          = wr_ptr_reg;
      assign rd_ptr_sel_all[gi]        = (RD_PTR_UNBUF != 0) ? rd_ptr_next : rd_ptr_reg;
      assign bus.o_wr_full[gi]         = full_reg;
      assign bus.o_wr_afull[gi]        = afull_reg;
      assign bus.o_rd_empty[gi]        = empty_reg;
      assign bus.o_words[gi*W +: W]    = words_reg;
    end
  endgenerate

  assign bus.o_wr_adr = {bus.i_wr_chan, wr_ptr_q_all[bus.i_wr_chan]};
  // Next-pointer form lets a synchronous-read RAM deliver the next word a cycle later.
  assign bus.o_rd_adr = {bus.i_rd_chan, rd_ptr_sel_all[bus.i_rd_chan]};
endmodule

// File: tb/tb_fifo_mc_ptr.sv
// Directed and randomized checks of fifo_mc_ptr against an occupancy model
// built from per-channel write/read totals.
module tb_fifo_mc_ptr;
  localparam int N_log = 2;
  localparam int C_log = 1;
  localparam int C     = 2 ** C_log;
  localparam int DEPTH = 2 ** N_log;
  localparam int AF    = 3;
  localparam int W     = N_log + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_mc_ptr_if #(.N_log(N_log), .C_log(C_log)) bus ();

  fifo_mc_ptr #(
    .N_log(N_log), .C_log(C_log), .AF_THRESH(AF), .RD_PTR_UNBUF(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: total words written and read per channel since the last reset/flush.
  int wc [C];
  int rc [C];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    for (int c = 0; c < C; c++) begin
      int cnt;
      cnt = wc[c] - rc[c];
      check($sformatf("%s words[%0d]", tag, c), 32'(bus.o_words[c*W +: W]), 32'(cnt));
      check($sformatf("%s full[%0d]", tag, c), 32'(bus.o_wr_full[c]), 32'(cnt == DEPTH));
      check($sformatf("%s empty[%0d]", tag, c), 32'(bus.o_rd_empty[c]), 32'(cnt == 0));
      check($sformatf("%s afull[%0d]", tag, c), 32'(bus.o_wr_afull[c]), 32'(cnt >= AF));
    end
  endtask

  // One clock of traffic: check addresses before the edge, status after it.
  task automatic step(input string tag, input bit we, input int wch,
                      input bit re, input int rch, input logic [C-1:0] fl);
    bit eff_wr, eff_rd;
    int exp_wa, exp_ra;
    bus.i_wr_advance = we;
    bus.i_wr_chan    = C_log'(wch);
    bus.i_rd_advance = re;
    bus.i_rd_chan    = C_log'(rch);
    bus.i_flush      = fl;
    eff_wr = we && (wc[wch] - rc[wch] < DEPTH) && !fl[wch];
    eff_rd = re && (wc[rch] - rc[rch] > 0) && !fl[rch];
    exp_wa = wch * DEPTH + (wc[wch] % DEPTH);
    exp_ra = rch * DEPTH + ((rc[rch] + int'(eff_rd)) % DEPTH);
    #2;
    check({tag, " wr_adr"}, 32'(bus.o_wr_adr), 32'(exp_wa));
    check({tag, " rd_adr"}, 32'(bus.o_rd_adr), 32'(exp_ra));
    @(posedge clk);
    #1;
    if (eff_wr) wc[wch]++;
    if (eff_rd) rc[rch]++;
    for (int c = 0; c < C; c++) if (fl[c]) begin wc[c] = 0; rc[c] = 0; end
    check_status(tag);
    $display("%s: we=%0b wch=%0d re=%0b rch=%0d flush=%b -> words=%h full=%b empty=%b afull=%b",
             tag, we, wch, re, rch, fl, bus.o_words, bus.o_wr_full, bus.o_rd_empty, bus.o_wr_afull);
  endtask

  task automatic idle_inputs();
    bus.i_wr_advance = 1'b0;
    bus.i_wr_chan    = '0;
    bus.i_rd_advance = 1'b0;
    bus.i_rd_chan    = '0;
    bus.i_flush      = '0;
  endtask

  task automatic check_reset(input string tag);
    for (int c = 0; c < C; c++) begin wc[c] = 0; rc[c] = 0; end
    idle_inputs();
    #1;
    check({tag, " rd_empty"}, 32'(bus.o_rd_empty), 32'({C{1'b1}}));
    check({tag, " wr_full"}, 32'(bus.o_wr_full), 32'd0);
    check({tag, " words"}, 32'(bus.o_words), 32'd0);
    check({tag, " wr_afull"}, 32'(bus.o_wr_afull), 32'd0);
    check({tag, " wr_adr"}, 32'(bus.o_wr_adr), 32'd0);
    check({tag, " rd_adr"}, 32'(bus.o_rd_adr), 32'd0);
    $display("%s: empty=%b full=%b words=%h", tag, bus.o_rd_empty, bus.o_wr_full, bus.o_words);
  endtask

  initial begin
    idle_inputs();
    for (int c = 0; c < C; c++) begin wc[c] = 0; rc[c] = 0; end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    // Fill channel 1, then attempt an overflow write.
    for (int i = 0; i < 4; i++) step($sformatf("fill1_%0d", i), 1, 1, 0, 0, 2'b00);
    step("overflow1", 1, 1, 0, 0, 2'b00);

    // Full channel: read wins, write dropped; then a wrapping write+read pair.
    step("full_wr_rd", 1, 1, 1, 1, 2'b00);
    step("wrap_wr_rd", 1, 1, 1, 1, 2'b00);

    // Empty channel 0: read dropped, write lands; next read sees next pointer 1.
    step("empty_wr_rd", 1, 0, 1, 0, 2'b00);
    step("drain0", 0, 0, 1, 0, 2'b00);
    step("underflow0", 0, 0, 1, 0, 2'b00);

    // Almost-full threshold on channel 0.
    for (int i = 0; i < 3; i++) step($sformatf("af0_%0d", i), 1, 0, 0, 0, 2'b00);
    step("af0_rd", 0, 0, 1, 0, 2'b00);

    // Flush channel 1 while writing to it, ch0 read continues.
    step("pre_flush_rd1", 0, 0, 1, 1, 2'b00);
    step("flush1", 1, 1, 1, 0, 2'b10);
    step("post_flush", 1, 1, 1, 0, 2'b00);

    // Reset mid-traffic overrides advance and flush.
    bus.i_wr_advance = 1'b1;
    bus.i_wr_chan    = 1'b0;
    bus.i_rd_advance = 1'b1;
    bus.i_rd_chan    = 1'b1;
    bus.i_flush      = 2'b01;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("mid_reset");

    // Randomized traffic, write-biased and read-biased phases.
    for (int i = 0; i < 400; i++) begin
      int wbias;
      logic [C-1:0] fl;
      wbias = (i < 200) ? 70 : 30;
      fl = ($urandom_range(0, 39) == 0) ? C'($urandom_range(1, 2 ** C - 1)) : '0;
      step($sformatf("rnd_%0d", i),
           ($urandom_range(0, 99) < wbias), int'($urandom_range(0, C - 1)),
           ($urandom_range(0, 99) < (100 - wbias)), int'($urandom_range(0, C - 1)), fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
